// File: rtl/eq_pkg.sv
// Shared types and real-valued helpers for the feed-forward equalizer.
package eq_pkg;

  typedef enum logic [1:0] {
    BYPASS = 2'd0,
    FIXED  = 2'd1,
    ADAPT  = 2'd2
  } eq_mode_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    RUN      = 2'd2,
    ADAPT_ST = 2'd3
  } eq_state_e;

  // Single-zero high-pass shape placed at the main cursor.
  function automatic real default_coef(input int unsigned k, input int unsigned main,
                                       input real t, input real tau);
    real c;
    c = 0.0;
    if (k == main) c = 1.0 + tau / t;
    else if (k == main + 1) c = -tau / t;
    return c;
  endfunction

  // Three-valued sign, zero maps to zero.
  function automatic real sgn(input real x);
    real s;
    s = 0.0;
    if (x > 0.0) s = 1.0;
    else if (x < 0.0) s = -1.0;
    return s;
  endfunction

  // Symmetric magnitude clamp.
  function automatic real clamp(input real x, input real cmax);
    real y;
    y = x;
    if (x > cmax) y = cmax;
    else if (x < -cmax) y = -cmax;
    return y;
  endfunction

endpackage

// File: rtl/eq_tap_line.sv
// Real-valued sample delay line with a saturating fill counter.
module eq_tap_line #(
  parameter int unsigned NUM_TAPS = 4,
  localparam int unsigned CW = $clog2(NUM_TAPS + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  real  din,
  output real  taps [NUM_TAPS],
  output logic fill_done_c
);

  logic [CW-1:0] fill_cnt;

  // Shift accepted samples in; tap 0 holds the newest.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_TAPS; k++) taps[k] <= 0.0;
    end else if (en) begin
      taps[0] <= din;
      for (int unsigned k = 1; k < NUM_TAPS; k++) taps[k] <= taps[k-1];
    end
  end

  // Count accepted samples, saturating once the line is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt <= '0;
    end else if (en && (fill_cnt != CW'(NUM_TAPS))) begin
      fill_cnt <= fill_cnt + CW'(1);
    end
  end

  // High when the sample accepted now completes (or finds) a full line.
  assign fill_done_c = (fill_cnt >= CW'(NUM_TAPS - 1));

endmodule

// File: rtl/ffe_equalizer.sv
// N-tap feed-forward equalizer with coefficient writes, bypass and sign-sign LMS.
module ffe_equalizer #(
  parameter int unsigned NUM_TAPS    = 4,
  parameter int unsigned MAIN_CURSOR = 0,
  parameter real         T           = 1.0e-12,
  parameter real         TAU         = 200.0e-12,
  parameter real         MU          = 1.0e-3,
  parameter real         AMP         = 1.0,
  parameter real         CMAX        = 256.0,
  localparam int unsigned AW = $clog2(NUM_TAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic          coef_wr,
  input  logic [AW-1:0] coef_addr,
  input  real           coef_wdata,
  input  real           equalizer_in,
  output real           equalizer_out,
  output logic          out_valid,
  output logic          decision,
  output real           eq_error
);

  import eq_pkg::*;

  eq_mode_e  mode_c;
  eq_state_e state;
  real       taps   [NUM_TAPS];
  real       line_c [NUM_TAPS];
  real       coef   [NUM_TAPS];
  real       fir_c;
  real       out_next_c;
  real       err_next_c;
  logic      dec_next_c;
  logic      fill_done_c;
  logic      adapt_c;
  logic      wr_ok_c;

  eq_tap_line #(.NUM_TAPS(NUM_TAPS)) u_tap_line (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .din         (equalizer_in),
    .taps        (taps),
    .fill_done_c (fill_done_c)
  );

  // Decode mode; the reserved code behaves as FIXED.
  always_comb begin
    case (mode)
      2'd0:    mode_c = BYPASS;
      2'd2:    mode_c = ADAPT;
      default: mode_c = FIXED;
    endcase
  end

  // Post-shift view of the line: the incoming sample is tap 0.
  always_comb begin
    line_c[0] = equalizer_in;
    for (int unsigned k = 1; k < NUM_TAPS; k++) line_c[k] = taps[k-1];
  end

  // FIR sum with the pre-edge coefficients, then slicer and error.
  always_comb begin
    fir_c = 0.0;
    for (int unsigned k = 0; k < NUM_TAPS; k++) fir_c = fir_c + coef[k] * line_c[k];
    out_next_c = (mode_c == BYPASS) ? equalizer_in : fir_c;
    dec_next_c = (out_next_c >= 0.0);
    err_next_c = out_next_c - (dec_next_c ? AMP : -AMP);
  end

  assign adapt_c = en && out_valid && (mode_c == ADAPT);
  assign wr_ok_c = coef_wr && (32'(coef_addr) < NUM_TAPS);

  // Coefficient bank: LMS step on non-main taps, host write takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_TAPS; k++) coef[k] <= default_coef(k, MAIN_CURSOR, T, TAU);
    end else begin
      if (adapt_c) begin
        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
          if (k != MAIN_CURSOR) coef[k] <= clamp(coef[k] - MU * sgn(eq_error) * sgn(taps[k]), CMAX);
        end
      end
      if (wr_ok_c) coef[coef_addr] <= clamp(coef_wdata, CMAX);
    end
  end

  // Registered equalizer outputs, updated only on accepted samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      equalizer_out <= 0.0;
      out_valid     <= 1'b0;
      decision      <= 1'b0;
      eq_error      <= 0.0;
    end else if (en) begin
      equalizer_out <= out_next_c;
      out_valid     <= out_valid || (mode_c == BYPASS) || fill_done_c;
      decision      <= dec_next_c;
      eq_error      <= err_next_c;
    end
  end

  // Operating state: warm-up tracking and RUN/ADAPT following the mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (en) begin
      case (state)
        IDLE:    state <= FILL;
        FILL:    if (fill_done_c) state <= (mode_c == ADAPT) ? ADAPT_ST : RUN;
        default: state <= (mode_c == ADAPT) ? ADAPT_ST : RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ffe_equalizer.sv
// Randomized scoreboard bench for ffe_equalizer against a behavioural model.
module tb_ffe_equalizer;

  localparam int unsigned N      = 4;
  localparam int unsigned MAINC  = 0;
  localparam real         TP     = 1.0e-12;
  localparam real         TAUP   = 2.0e-12;
  localparam real         MUP    = 0.01;
  localparam real         AMPP   = 1.0;
  localparam real         CMAXP  = 256.0;
  localparam logic [1:0]  M_BYP  = 2'd0;
  localparam logic [1:0]  M_FIX  = 2'd1;
  localparam logic [1:0]  M_ADP  = 2'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = M_FIX;
  logic       coef_wr = 1'b0;
  logic [1:0] coef_addr = 2'd0;
  real        coef_wdata = 0.0;
  real        equalizer_in = 0.0;
  real        equalizer_out;
  logic       out_valid;
  logic       decision;
  real        eq_error;

  always #5 clk = ~clk;

  ffe_equalizer #(
    .NUM_TAPS(N), .MAIN_CURSOR(MAINC), .T(TP), .TAU(TAUP),
    .MU(MUP), .AMP(AMPP), .CMAX(CMAXP)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .equalizer_in(equalizer_in), .equalizer_out(equalizer_out),
    .out_valid(out_valid), .decision(decision), .eq_error(eq_error)
  );

  // Expected post-edge observables, one entry per driven clock.
  real  q_out [$];
  logic q_val [$];
  logic q_dec [$];
  real  q_err [$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: sample history, coefficients, warm-up and last error.
  real  m_hist [N];
  real  m_coef [N];
  int   m_cnt;
  logic m_valid;
  logic m_dec;
  real  m_out;
  real  m_err;

  function automatic real f_sgn(input real x);
    return (x > 0.0) ? 1.0 : ((x < 0.0) ? -1.0 : 0.0);
  endfunction

  function automatic real f_clamp(input real x);
    return (x > CMAXP) ? CMAXP : ((x < -CMAXP) ? -CMAXP : x);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_hist[k] = 0.0;
      m_coef[k] = 0.0;
    end
    m_coef[MAINC] = 1.0 + TAUP / TP;
    if (MAINC + 1 < N) m_coef[MAINC + 1] = -TAUP / TP;
    m_cnt = 0; m_valid = 1'b0; m_dec = 1'b0; m_out = 0.0; m_err = 0.0;
  endtask

  task automatic model_edge(input logic r, input logic e, input logic [1:0] md,
                            input logic wr, input logic [1:0] a, input real wd, input real x);
    real nh [N];
    real nc [N];
    real o;
    if (r) begin
      model_reset();
    end else begin
      for (int k = 0; k < N; k++) nc[k] = m_coef[k];
      if (e) begin
        nh[0] = x;
        for (int k = 1; k < N; k++) nh[k] = m_hist[k-1];
        if (md == M_BYP) o = x;
        else begin
          o = 0.0;
          for (int k = 0; k < N; k++) o = o + m_coef[k] * nh[k];
        end
        if (md == M_ADP && m_valid)
          for (int k = 0; k < N; k++)
            if (k != MAINC) nc[k] = f_clamp(m_coef[k] - MUP * f_sgn(m_err) * f_sgn(m_hist[k]));
        m_cnt   = (m_cnt < N) ? m_cnt + 1 : N;
        m_valid = m_valid | (md == M_BYP) | (m_cnt == N);
        m_out   = o;
        m_dec   = (o >= 0.0);
        m_err   = o - (m_dec ? AMPP : -AMPP);
        for (int k = 0; k < N; k++) m_hist[k] = nh[k];
      end
      if (wr && int'(a) < N) nc[a] = f_clamp(wd);
      for (int k = 0; k < N; k++) m_coef[k] = nc[k];
    end
    q_out.push_back(m_out);
    q_val.push_back(m_valid);
    q_dec.push_back(m_dec);
    q_err.push_back(m_err);
  endtask

  // Drive one clock's worth of inputs mid-cycle and predict the result.
  task automatic drive(input logic r, input logic e, input logic [1:0] md,
                       input logic wr, input logic [1:0] a, input real wd, input real x);
    @(negedge clk);
    #1;
    rst = r; en = e; mode = md; coef_wr = wr; coef_addr = a; coef_wdata = wd; equalizer_in = x;
    model_edge(r, e, md, wr, a, wd, x);
  endtask

  task automatic sample(input logic [1:0] md, input real x);
    drive(1'b0, 1'b1, md, 1'b0, 2'd0, 0.0, x);
  endtask

  task automatic hold();
    drive(1'b0, 1'b0, M_FIX, 1'b0, 2'd0, 0.0, 5.0);
  endtask

  task automatic wcoef(input logic [1:0] a, input real v);
    drive(1'b0, 1'b0, M_FIX, 1'b1, a, v, 0.0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b1, M_ADP, 1'b1, 2'd1, 7.0, 9.0);
  endtask

  task automatic chk_r(input string nm, input real act, input real exp);
    real tol;
    tol = 1.0e-9 + 1.0e-9 * ((exp < 0.0) ? -exp : exp);
    vectors++;
    if (!((act - exp) <= tol && (exp - act) <= tol)) begin
      miscompares++;
      $display("FAIL %s: got %g expected %g at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: after every edge that has a prediction, pop and compare.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (q_out.size() > 0) begin
        chk_r("equalizer_out", equalizer_out, q_out.pop_front());
        chk_b("out_valid", out_valid, q_val.pop_front());
        chk_b("decision", decision, q_dec.pop_front());
        chk_r("eq_error", eq_error, q_err.pop_front());
      end
    end
  end

  function automatic real rnd_sample();
    return real'($urandom_range(0, 4000)) / 1000.0 - 2.0;
  endfunction

  initial begin
    model_reset();
    do_reset();
    do_reset();

    // Default coefficients, step input.
    for (int i = 0; i < 6; i++) sample(M_FIX, 1.0);

    // Warm-up with an en gap.
    do_reset();
    sample(M_FIX, rnd_sample());
    sample(M_FIX, rnd_sample());
    for (int i = 0; i < 5; i++) hold();
    sample(M_FIX, rnd_sample());
    sample(M_FIX, rnd_sample());
    sample(M_FIX, rnd_sample());

    // Coefficient writes, impulse response, clamp.
    do_reset();
    wcoef(2'd0, 1.0); wcoef(2'd1, 0.0); wcoef(2'd2, 0.5); wcoef(2'd3, 0.0);
    sample(M_FIX, 1.0);
    for (int i = 0; i < 4; i++) sample(M_FIX, 0.0);
    wcoef(2'd0, 1000.0);
    sample(M_FIX, 1.0);
    sample(M_FIX, 0.0);
    wcoef(2'd2, -1000.0);
    sample(M_FIX, 0.0);
    sample(M_FIX, -1.0);
    sample(M_FIX, 0.0);
    sample(M_FIX, 0.0);

    // Bypass, valid from the first sample.
    do_reset();
    sample(M_BYP, 0.7);
    sample(M_BYP, -0.3);
    sample(M_FIX, 0.2);

    // Sign-sign LMS with a same-edge write override.
    do_reset();
    wcoef(2'd0, 1.0); wcoef(2'd1, 0.2); wcoef(2'd2, 0.0); wcoef(2'd3, 0.0);
    for (int i = 0; i < 12; i++) sample(M_ADP, (i % 2 == 0) ? 1.0 : -1.0);
    drive(1'b0, 1'b1, M_ADP, 1'b1, 2'd1, 0.5, 1.0);
    for (int i = 0; i < 8; i++) sample(M_ADP, (i % 2 == 0) ? -1.0 : 1.0);

    // Reset in the middle of adaptation, then default step again.
    do_reset();
    for (int i = 0; i < 5; i++) sample(M_FIX, 1.0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic       r, e, wr;
      logic [1:0] md, a;
      real        wd;
      r  = ($urandom_range(0, 59) == 0);
      e  = ($urandom_range(0, 9) < 8);
      md = 2'($urandom_range(0, 3));
      wr = ($urandom_range(0, 9) == 0);
      a  = 2'($urandom_range(0, 3));
      wd = real'($urandom_range(0, 6000)) / 10.0 - 300.0;
      drive(r, e, md, wr, a, wd, rnd_sample());
    end

    // Drain the scoreboard with a bounded wait.
    hold();
    for (int i = 0; i < 10 && q_out.size() > 0; i++) @(posedge clk);
    #3;
    if (q_out.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left, expected 0", q_out.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
